// File: rtl/prelude_run_ctrl.sv
// prelude_run_ctrl: run/debug sequencer for the Prelude core.
// Accepts byte commands over valid/ready, owns the instruction memory write
// port, drives the core reset and a per-cycle clock enable, and stops on a
// PC breakpoint.
// Optional build macro PRELUDE_ICOUNT_EN: when defined, a saturating 16-bit
// retired-instruction counter is built; otherwise icount is tied to zero.
module prelude_run_ctrl #(
  parameter int ADDR_W = 8,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [7:0]        cmd_data,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_reset,
  output logic              cpu_en,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic [1:0]        state,
  output logic              err,
  output logic [15:0]       icount
);

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_HALT = 2'b01,
    S_RUN  = 2'b10,
    S_STEP = 2'b11
  } state_t;

  localparam logic [2:0] OP_RESET_CPU = 3'b000;
  localparam logic [2:0] OP_LOAD_ADDR = 3'b001;
  localparam logic [2:0] OP_LOAD_BYTE = 3'b010;
  localparam logic [2:0] OP_RUN       = 3'b011;
  localparam logic [2:0] OP_HALT      = 3'b100;
  localparam logic [2:0] OP_STEP      = 3'b101;
  localparam logic [2:0] OP_SET_BP    = 3'b110;
  localparam logic [2:0] OP_CLR_BP    = 3'b111;

  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic                r_cpu_reset;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [7:0]          r_imem_wdata;
  logic                r_err;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_bp_valid;
  logic [ADDR_W-1:0]   r_bp_addr;
  logic [STEP_W-1:0]   r_step_cnt;
  logic                r_skip;

  state_t              w_state_nxt;
  logic                w_bp_hit;
  logic                w_cpu_en;
  logic                w_accept;
  logic                w_editable;
  logic                w_illegal;
  logic                w_do_write;
  logic                w_do_step;

  // A breakpoint only fires in RUN and is masked for the first enabled cycle after a resume.
  assign w_bp_hit   = (r_state == S_RUN) & r_bp_valid & (pc == r_bp_addr) & ~r_skip;
  assign w_cpu_en   = ((r_state == S_RUN) & ~w_bp_hit) | (r_state == S_STEP);
  assign w_editable = (r_state == S_LOAD) | (r_state == S_HALT);
  assign cmd_ready  = ~reset & (r_state != S_STEP);
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_do_write = w_accept & (cmd_op == OP_LOAD_BYTE) & w_editable;
  assign w_do_step  = w_accept & (cmd_op == OP_STEP) & (r_state == S_HALT) & (cmd_data != 8'h00);

  // Next state: breakpoint / step exhaustion first, an accepted command overrides.
  always_comb begin
    w_state_nxt = r_state;
    if (w_bp_hit) begin
      w_state_nxt = S_HALT;
    end else if ((r_state == S_STEP) && (r_step_cnt == STEP_ONE)) begin
      w_state_nxt = S_HALT;
    end else begin
      w_state_nxt = r_state;
    end
    if (w_accept) begin
      case (cmd_op)
        OP_RESET_CPU: w_state_nxt = S_LOAD;
        OP_RUN:       if (w_editable) w_state_nxt = S_RUN;
        OP_HALT:      if (r_state == S_RUN) w_state_nxt = S_HALT;
        OP_STEP:      if (w_do_step) w_state_nxt = S_STEP;
        default:      ;
      endcase
    end
  end

  // Commands that are not allowed in the current state only raise err.
  always_comb begin
    w_illegal = 1'b0;
    case (cmd_op)
      OP_LOAD_ADDR: w_illegal = ~w_editable;
      OP_LOAD_BYTE: w_illegal = ~w_editable;
      OP_HALT:      w_illegal = (r_state == S_LOAD);
      OP_STEP:      w_illegal = (r_state == S_LOAD) | (r_state == S_RUN);
      default:      w_illegal = 1'b0;
    endcase
  end

  // Run-state register; core reset is held exactly while the next state is LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_cpu_reset <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_reset <= (w_state_nxt == S_LOAD);
    end
  end

  // Instruction memory write port and auto-incrementing load pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_imem_we    <= 1'b0;
      r_imem_addr  <= {ADDR_W{1'b0}};
      r_imem_wdata <= 8'h00;
      r_ptr        <= {ADDR_W{1'b0}};
    end else begin
      r_imem_we <= w_do_write;
      if (w_do_write) begin
        r_imem_addr  <= r_ptr;
        r_imem_wdata <= cmd_data;
        r_ptr        <= r_ptr + PTR_ONE;
      end else if (w_accept && (cmd_op == OP_LOAD_ADDR) && w_editable) begin
        r_ptr <= ADDR_W'(cmd_data);
      end
    end
  end

  // Breakpoint register and resume-skip flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bp_valid <= 1'b0;
      r_bp_addr  <= {ADDR_W{1'b0}};
      r_skip     <= 1'b0;
    end else begin
      if (w_accept && (cmd_op == OP_SET_BP)) begin
        r_bp_valid <= 1'b1;
        r_bp_addr  <= ADDR_W'(cmd_data);
      end else if (w_accept && (cmd_op == OP_CLR_BP)) begin
        r_bp_valid <= 1'b0;
      end
      if (w_accept && (cmd_op == OP_RESET_CPU)) begin
        r_skip <= 1'b0;
      end else if (w_accept && (cmd_op == OP_RUN) && w_editable) begin
        r_skip <= 1'b1;
      end else if (w_cpu_en) begin
        r_skip <= 1'b0;
      end
    end
  end

  // Step counter loads on an accepted non-zero STEP and counts down while stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step_cnt <= {STEP_W{1'b0}};
    end else if (w_do_step) begin
      r_step_cnt <= STEP_W'(cmd_data);
    end else if (r_state == S_STEP) begin
      r_step_cnt <= r_step_cnt - STEP_ONE;
    end
  end

  // Sticky error flag for commands issued in a state that does not allow them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_err <= 1'b1;
    end
  end

`ifdef PRELUDE_ICOUNT_EN
  logic [15:0] r_icount;

  // Saturating count of enabled core cycles; RESET_CPU clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_icount <= 16'h0000;
    end else if (w_accept && (cmd_op == OP_RESET_CPU)) begin
      r_icount <= 16'h0000;
    end else if (w_cpu_en && (r_icount != 16'hFFFF)) begin
      r_icount <= r_icount + 16'h0001;
    end
  end

  assign icount = r_icount;
`else
  assign icount = 16'h0000;
`endif

  assign state      = r_state;
  assign cpu_reset  = r_cpu_reset;
  assign cpu_en     = w_cpu_en;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign err        = r_err;

endmodule

// File: tb/tb_prelude_run_ctrl.sv
// Bench for prelude_run_ctrl: directed test-plan sequence followed by
// randomized commands, all checked every cycle against a behavioural model
// of the controller and of a straight-line core (pc += 1 when enabled).
module tb_prelude_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic [7:0]  pc;
  logic        cpu_reset;
  logic        cpu_en;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [7:0]  imem_wdata;
  logic [1:0]  state;
  logic        err;
  logic [15:0] icount;

  always #5 clk = ~clk;

  prelude_run_ctrl #(.ADDR_W(8), .STEP_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .pc(pc),
    .cpu_reset(cpu_reset), .cpu_en(cpu_en),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .state(state), .err(err), .icount(icount)
  );

  localparam int LOAD = 0, HALT = 1, RUN = 2, STEP = 3;

  int n_cmp = 0;
  int n_bad = 0;

  // model of the controller's visible behaviour
  int m_state, m_err, m_ptr, m_bpv, m_bpa, m_steps, m_skip, m_icount;
  int m_we, m_waddr, m_wdata;
  int core_pc;
  int en_seen = 0;
  int last_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = LOAD; m_err = 0; m_ptr = 0; m_bpv = 0; m_bpa = 0;
    m_steps = 0; m_skip = 0; m_icount = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
  endtask

  // One clock: check outputs against the model, then advance model and core.
  task automatic cycle();
    int hit, en, rdy, acc, nst;
    pc = 8'(core_pc);
    #1;
    rdy = (!reset && m_state != STEP) ? 1 : 0;
    hit = (m_state == RUN && m_bpv != 0 && core_pc == m_bpa && m_skip == 0) ? 1 : 0;
    en  = ((m_state == RUN && hit == 0) || m_state == STEP) ? 1 : 0;
    chk("cmd_ready", 32'(cmd_ready), 32'(rdy));
    chk("cpu_en", 32'(cpu_en), 32'(en));
    chk("state", 32'(state), 32'(m_state));
    chk("cpu_reset", 32'(cpu_reset), (m_state == LOAD) ? 32'd1 : 32'd0);
    chk("err", 32'(err), 32'(m_err));
    chk("imem_we", 32'(imem_we), 32'(m_we));
    if (m_we != 0) begin
      chk("imem_addr", 32'(imem_addr), 32'(m_waddr));
      chk("imem_wdata", 32'(imem_wdata), 32'(m_wdata));
    end
`ifdef PRELUDE_ICOUNT_EN
    chk("icount", 32'(icount), 32'(m_icount));
`else
    chk("icount", 32'(icount), 32'd0);
`endif
    if (cpu_en === 1'b1) en_seen++;
    acc = (cmd_valid && rdy != 0) ? 1 : 0;
    last_acc = acc;
    @(posedge clk);
    if (m_state == LOAD) core_pc = 0;
    else if (en != 0) core_pc = (core_pc + 1) % 256;
    if (reset) begin
      model_reset();
    end else begin
      m_we = 0;
      nst = m_state;
      if (en != 0) begin
        m_skip = 0;
        if (m_icount < 65535) m_icount++;
      end
      if (hit != 0) nst = HALT;
      if (m_state == STEP) begin
        m_steps--;
        if (m_steps == 0) nst = HALT;
      end
      if (acc != 0) begin
        case (int'(cmd_op))
          0: begin nst = LOAD; m_skip = 0; m_icount = 0; end
          1: if (m_state == LOAD || m_state == HALT) m_ptr = int'(cmd_data); else m_err = 1;
          2: if (m_state == LOAD || m_state == HALT) begin
               m_we = 1; m_waddr = m_ptr; m_wdata = int'(cmd_data);
               m_ptr = (m_ptr + 1) % 256;
             end else m_err = 1;
          3: if (m_state == LOAD || m_state == HALT) begin nst = RUN; m_skip = 1; end
          4: if (m_state == RUN) nst = HALT; else if (m_state == LOAD) m_err = 1;
          5: if (m_state == HALT) begin
               if (cmd_data != 8'h00) begin m_steps = int'(cmd_data); nst = STEP; end
             end else m_err = 1;
          6: begin m_bpv = 1; m_bpa = int'(cmd_data); end
          default: m_bpv = 0;
        endcase
      end
      m_state = nst;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic send(input int op, input int data);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_data  = 8'(data);
    last_acc  = 0;
    for (int k = 0; k < 300; k++) begin
      cycle();
      if (last_acc != 0) break;
    end
    if (last_acc == 0) chk("accept_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  int base;
  int r;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00; pc = 8'h00;
    core_pc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    do_reset();

    // program load, including pointer wrap
    send(1, 8'h10); send(2, 8'hB1); send(2, 8'h8A); idle(2);
    send(1, 8'hFF); send(2, 8'h44); send(2, 8'h44); idle(1);

    // run then halt after 5 cycles: 6 enabled cycles
    base = en_seen;
    send(3, 0); idle(5); send(4, 0); idle(2);
    chk("run_en_cycles", 32'(en_seen - base), 32'd6);
    chk("halt_state", 32'(state), 32'd1);

    // breakpoint at 3 from LOAD, then resume past it
    send(0, 0); send(6, 8'h03); send(3, 0); idle(8);
    chk("bp_state", 32'(state), 32'd1);
    send(3, 0); idle(3);
    chk("resume_state", 32'(state), 32'd2);
    send(7, 0); send(4, 0); idle(1);

    // step 3 then step 0
    base = en_seen;
    send(5, 3); send(4, 0); idle(1);
    chk("step3_en_cycles", 32'(en_seen - base), 32'd3);
    base = en_seen;
    send(5, 0); idle(2);
    chk("step0_en_cycles", 32'(en_seen - base), 32'd0);

    // illegal load while running; RESET_CPU clears icount
    send(3, 0); send(2, 8'h55); idle(2);
    chk("err_sticky", 32'(err), 32'd1);
    send(0, 0); idle(2);
    chk("err_after_reset_cpu", 32'(err), 32'd1);
    do_reset();
    chk("err_cleared", 32'(err), 32'd0);

    // randomized commands
    for (int c = 0; c < 4000; c++) begin
      if (!cmd_valid || last_acc != 0) begin
        cmd_valid = ($urandom % 3 != 0);
        r = $urandom % 16;
        case (r)
          0:             begin cmd_op = 3'd0; cmd_data = 8'($urandom); end
          1, 2:          begin cmd_op = 3'd1; cmd_data = 8'($urandom); end
          3, 4, 5:       begin cmd_op = 3'd2; cmd_data = 8'($urandom); end
          6, 7, 8:       begin cmd_op = 3'd3; cmd_data = 8'($urandom); end
          9, 10:         begin cmd_op = 3'd4; cmd_data = 8'($urandom); end
          11, 12:        begin cmd_op = 3'd5; cmd_data = 8'($urandom_range(0, 6)); end
          13, 14:        begin cmd_op = 3'd6; cmd_data = 8'($urandom_range(0, 12)); end
          default:       begin cmd_op = 3'd7; cmd_data = 8'($urandom); end
        endcase
      end
      reset = ($urandom % 300 == 0);
      cycle();
    end
    reset = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prelude_run_ctrl.md
Name: prelude_run_ctrl

Overview:
Run/debug controller that sequences the Prelude core and owns its instruction memory write port. Accepts byte commands over a valid/ready interface to load a program, release the core from reset, run, halt, single/multi-step, and stop on a PC breakpoint. It drives the core's reset and a per-cycle clock enable. The PC advances, and registers write, only in cycles where cpu_en=1.

Parameters:
ADDR_W, 8, width of core PC and instruction memory address
STEP_W, 8, width of step counter

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a clk edge
cmd_op  in  3  opcode: 000 RESET_CPU, 001 LOAD_ADDR, 010 LOAD_BYTE, 011 RUN, 100 HALT, 101 STEP, 110 SET_BP, 111 CLR_BP
cmd_data  in  8  command operand
pc  in  ADDR_W  current core PC
cpu_reset  out  1  core synchronous reset
cpu_en  out  1  core clock enable, combinational
imem_we  out  1  instruction memory write strobe, registered
imem_addr  out  ADDR_W  write address, registered
imem_wdata  out  8  write data, registered
state  out  2  00 LOAD, 01 HALT, 10 RUN, 11 STEP
err  out  1  sticky: illegal command for the current state
icount  out  16  retired-instruction count (see Optional Feature)

Behaviour:
- Reset values: state=LOAD, cpu_reset=1, cpu_en=0, imem_we=0, imem_addr=0, imem_wdata=0, err=0, load pointer=0, bp_valid=0, bp_addr=0, step_cnt=0, skip=0, icount=0. cmd_ready=0 while reset=1.
- cmd_ready=1 in LOAD, HALT and RUN. cmd_ready=0 in STEP; commands stall until the step sequence completes.
- cpu_reset=1 exactly when state=LOAD (registered with state).
- cpu_en = (state==RUN & ~(bp_valid & pc==bp_addr & ~skip)) | (state==STEP).
- LOAD_ADDR (LOAD/HALT): pointer <= cmd_data.
- LOAD_BYTE (LOAD/HALT): next cycle imem_we=1 for exactly one cycle, with imem_addr=pointer and imem_wdata=cmd_data. Pointer increments mod 2^ADDR_W, so 0xFF wraps to 0x00. Back-to-back LOAD_BYTEs give one strobe per cycle.
- RUN from LOAD or HALT: state<=RUN and skip<=1. skip clears after the first cycle with cpu_en=1, so resuming from a breakpoint executes the breakpoint instruction once. From LOAD, cpu_reset drops in the same edge and the core starts at PC 0.
- Breakpoint: in RUN, if bp_valid & pc==bp_addr & ~skip, then cpu_en=0 that cycle and state<=HALT. The instruction at bp_addr is not executed.
- HALT in RUN: the acceptance cycle still has cpu_en=1; from the next cycle state=HALT and cpu_en=0. HALT in HALT is a no-op. HALT in LOAD sets err.
- STEP from HALT: if cmd_data==0, the command is accepted with no effect. Otherwise step_cnt<=cmd_data and state<=STEP. Each STEP cycle decrements step_cnt. When step_cnt==1, state<=HALT, giving exactly N enabled cycles. Breakpoints are ignored in STEP. STEP in LOAD or RUN sets err.
- SET_BP: bp_addr<=cmd_data, bp_valid<=1, in any state. CLR_BP: bp_valid<=0, in any state.
- RESET_CPU: accepted in any ready state. state<=LOAD and skip<=0. Pointer and breakpoint are preserved.
- Illegal command (LOAD_ADDR/LOAD_BYTE in RUN; cases listed above): accepted, no effect, err<=1. err clears only on reset.
- A breakpoint hit and an accepted command in the same cycle: the command takes priority for the next state. The breakpoint still suppresses cpu_en in that cycle.
- reset asserted mid-STEP or mid-RUN: all registers return to reset values at the next edge. An in-flight imem_we is dropped.

Optional Feature:
PRELUDE_ICOUNT_EN
- Defined: icount increments on every cycle with cpu_en=1, saturates at 0xFFFF, and clears on reset or on an accepted RESET_CPU.
- Undefined: icount is tied to 0 and no counter logic is built.

Test Plan:
- reset; LOAD_ADDR 0x10; LOAD_BYTE 0xB1, 0x8A back-to-back -> imem_we pulses at addr 0x10 data 0xB1, then 0x11 data 0x8A; state=LOAD, cpu_reset=1.
- LOAD_ADDR 0xFF; LOAD_BYTE 0x44 twice -> writes at 0xFF then 0x00.
- RUN from LOAD, then HALT after 5 cycles -> cpu_reset falls at the RUN edge; cpu_en=1 for 6 cycles including the HALT acceptance cycle; state=HALT.
- SET_BP 0x03; RUN from LOAD with a straight-line program -> cpu_en drops when pc=0x03; state=HALT. RUN again -> pc advances past 0x03.
- From HALT, STEP 3 -> cmd_ready=0 for 3 cycles, cpu_en=1 exactly 3 cycles, then HALT. STEP 0 -> no enable cycles.
- LOAD_BYTE while RUN -> no imem_we, err=1 until reset. With PRELUDE_ICOUNT_EN defined, icount equals the number of cpu_en cycles observed, and RESET_CPU clears it to 0.
